matrix_ram_loader: RTL and testbench

//   Fills the 256-bit single-port matrix RAM with operand words. It receives a byte stream

---
 rtl/matrix_ram_loader.sv | 165 ++++++++++++++++
 tb/tb_matrix_ram_loader.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ram_loader.sv
// matrix_ram_loader: packs a valid/ready byte stream into DATA_W-bit words and
// writes them to consecutive matrix RAM addresses starting at BASE_ADDR.
// Optional feature macro: READBACK_VERIFY_EN adds a read-back compare after
// every write (VWAIT/VCMP states, sticky error output).
module matrix_ram_loader #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 2,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [7:0]        LAST_WORD = 8'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
`ifdef READBACK_VERIFY_EN
  localparam logic [2:0] S_VWAIT   = 3'd4;
  localparam logic [2:0] S_VCMP    = 3'd5;
`endif

  logic [2:0]        state;
  logic [BC_W-1:0]   byte_cnt;
  logic [7:0]        word_cnt;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] packed_next;
  logic              last_word;

  // Drop one byte into its lane of the word buffer (byte 0 = LSB lane).
  function automatic logic [DATA_W-1:0] pack_byte(
    input logic [DATA_W-1:0] buf_in,
    input logic [BC_W-1:0]   lane,
    input logic [7:0]        b
  );
    logic [DATA_W-1:0] r;
    logic [BC_W+2:0]   ofs;
    r   = buf_in;
    ofs = {lane, 3'b000};
    r[ofs +: 8] = b;
    return r;
  endfunction

  // Word buffer with the incoming byte merged into the current lane.
  always_comb begin
    packed_next = pack_byte(wbuf, byte_cnt, in_data);
    last_word   = (word_cnt == LAST_WORD);
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == S_COLLECT);
    ram_we    = (state == S_WRITE);
    busy      = (state != S_IDLE) && (state != S_DONE);
    done      = (state == S_DONE);
    ram_wdata = wdata_q;
  end

`ifdef READBACK_VERIFY_EN
  logic vw_cnt;
  logic err_q;
  assign error = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign error        = 1'b0;
`endif

  // Load-run FSM: collect bytes, write the packed word, advance the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      ram_addr <= BASE;
      wbuf     <= '0;
      wdata_q  <= '0;
`ifdef READBACK_VERIFY_EN
      vw_cnt   <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_COLLECT;
            word_cnt <= '0;
            byte_cnt <= '0;
            ram_addr <= BASE;
`ifdef READBACK_VERIFY_EN
            err_q    <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (in_valid) begin
            wbuf <= packed_next;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              wdata_q  <= packed_next;
              state    <= S_WRITE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
`ifdef READBACK_VERIFY_EN
        S_WRITE: begin
          vw_cnt <= 1'b0;
          state  <= S_VWAIT;
        end
        // Give the RAM two cycles before sampling the read-back data.
        S_VWAIT: begin
          if (vw_cnt) state <= S_VCMP;
          else        vw_cnt <= 1'b1;
        end
        S_VCMP: begin
          if (ram_rdata != wdata_q) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else if (last_word) begin
            state <= S_DONE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
            state    <= S_COLLECT;
          end
        end
`else
        S_WRITE: begin
          if (last_word) begin
            state <= S_DONE;
          end else begin
            ram_addr <= ram_addr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
            state    <= S_COLLECT;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_ram_loader.sv
// Bench for matrix_ram_loader: scoreboard of expected RAM writes versus writes
// captured from the DUT, plus control/status checks per scenario.
module tb_matrix_ram_loader;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 8;
`ifdef READBACK_VERIFY_EN
  localparam int GAP    = 36;
  localparam int DONE_D = 73;
`else
  localparam int GAP    = 33;
  localparam int DONE_D = 67;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              done;
  logic              error;

  matrix_ram_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WORDS(2), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                c;
  } wr_t;

  wr_t obs[$];
  wr_t exq[$];
  wr_t mon_w;
  int  cyc = 0;
  int  start_c = 0;
  int  done_c = 0;
  bit  done_seen = 0;
  int  checks = 0;
  int  errors = 0;
  bit  corrupt = 0;

  logic [DATA_W-1:0] mem [0:255];

  // RAM model plus write/start/done monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      mon_w.addr = ram_addr;
      mon_w.data = ram_wdata;
      mon_w.c    = cyc;
      obs.push_back(mon_w);
    end
    if (start && !busy && !rst) begin
      start_c   = cyc;
      done_seen = 0;
    end
    if (done && !done_seen) begin
      done_c    = cyc;
      done_seen = 1;
    end
  end

  // Read port, optionally corrupting bit 100 of address 0
  always_comb begin
    ram_rdata = mem[ram_addr];
    if (corrupt && ram_addr == 8'd0) ram_rdata[100] = ~ram_rdata[100];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_expected(input int first, input int nw, input int base);
    wr_t w;
    for (int i = 0; i < nw; i++) begin
      w.addr = ADDR_W'(base + i);
      w.c    = 0;
      for (int k = 0; k < 32; k++) w.data[8*k +: 8] = 8'(first + 32*i + k);
      exq.push_back(w);
    end
  endtask

  // Offer n bytes (first, first+1, ...) and advance only on accepted handshakes.
  task automatic feed(input int n, input int first, input bit rnd);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < n && guard < 3000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = 8'(first + idx);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (idx < n) begin
      checks++; errors++;
      $display("FAIL feed_timeout: accepted %0d bytes, expected %0d", idx, n);
    end
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done && i < 400) begin
      step();
      i++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: done=%0b after %0d cycles, expected 1", done, i);
    end
  endtask

  task automatic clear_sb();
    obs.delete();
    exq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    step(); step();
    checks++;
    if ({in_ready, busy, done, error, ram_we} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: {rdy,busy,done,err,we}=%b, expected 00000",
               {in_ready, busy, done, error, ram_we});
    end
    checks++;
    if (ram_addr !== 8'd0) begin
      errors++; $display("FAIL reset_addr: got %0d, expected 0", ram_addr);
    end
    checks++;
    if (ram_wdata !== '0) begin
      errors++; $display("FAIL reset_wdata: got %h, expected 0", ram_wdata);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({in_ready, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: {rdy,busy}=%b, expected 00", {in_ready, busy});
    end
  endtask

  task automatic test_stream();
    clear_sb();
    push_expected(8'h00, 2, 0);
    pulse_start();
    feed(64, 8'h00, 1'b0);
    wait_done();
    step();
    checks++;
    if (obs.size() !== exq.size()) begin
      errors++; $display("FAIL stream_count: got %0d writes, expected %0d", obs.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].addr !== exq[i].addr || obs[i].data !== exq[i].data) begin
        errors++;
        $display("FAIL stream_word%0d: got @%0d %h, expected @%0d %h",
                 i, obs[i].addr, obs[i].data, exq[i].addr, exq[i].data);
      end
    end
    if (obs.size() == 2) begin
      checks++;
      if (obs[0].c - start_c !== 33) begin
        errors++; $display("FAIL stream_latency: got %0d, expected 33", obs[0].c - start_c);
      end
      checks++;
      if (obs[1].c - obs[0].c !== GAP) begin
        errors++; $display("FAIL stream_gap: got %0d, expected %0d", obs[1].c - obs[0].c, GAP);
      end
    end
    checks++;
    if (done_c - start_c !== DONE_D) begin
      errors++; $display("FAIL stream_done_cycle: got %0d, expected %0d", done_c - start_c, DONE_D);
    end
    checks++;
    if ({done, busy, in_ready, error} !== 4'b1000) begin
      errors++; $display("FAIL stream_status: {done,busy,rdy,err}=%b, expected 1000",
                         {done, busy, in_ready, error});
    end
  endtask

  task automatic test_random_valid();
    clear_sb();
    push_expected(8'h55, 2, 0);
    pulse_start();
    feed(64, 8'h55, 1'b1);
    wait_done();
    checks++;
    if (obs.size() !== exq.size()) begin
      errors++; $display("FAIL random_count: got %0d writes, expected %0d", obs.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].addr !== exq[i].addr || obs[i].data !== exq[i].data) begin
        errors++;
        $display("FAIL random_word%0d: got @%0d %h, expected @%0d %h",
                 i, obs[i].addr, obs[i].data, exq[i].addr, exq[i].data);
      end
    end
  endtask

  task automatic test_rst_mid();
    clear_sb();
    push_expected(8'h10, 1, 0);
    pulse_start();
    feed(50, 8'h10, 1'b0);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({busy, in_ready, done} !== 3'b000 || ram_addr !== 8'd0) begin
      errors++; $display("FAIL rstmid_state: {busy,rdy,done}=%b addr=%0d, expected 000 addr=0",
                         {busy, in_ready, done}, ram_addr);
    end
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (obs.size() !== 1) begin
      errors++; $display("FAIL rstmid_count: got %0d writes, expected 1", obs.size());
    end else begin
      checks++;
      if (obs[0].addr !== exq[0].addr || obs[0].data !== exq[0].data) begin
        errors++; $display("FAIL rstmid_word0: got @%0d %h, expected @%0d %h",
                           obs[0].addr, obs[0].data, exq[0].addr, exq[0].data);
      end
    end
    clear_sb();
    push_expected(8'h90, 2, 0);
    pulse_start();
    feed(64, 8'h90, 1'b0);
    wait_done();
    checks++;
    if (obs.size() !== 2) begin
      errors++; $display("FAIL rerun_count: got %0d writes, expected 2", obs.size());
    end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].addr !== exq[i].addr || obs[i].data !== exq[i].data) begin
        errors++; $display("FAIL rerun_word%0d: got @%0d %h, expected @%0d %h",
                           i, obs[i].addr, obs[i].data, exq[i].addr, exq[i].data);
      end
    end
  endtask

  task automatic test_start_while_busy();
    clear_sb();
    push_expected(8'hA0, 2, 0);
    pulse_start();
    feed(10, 8'hA0, 1'b0);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_start: {busy,rdy}=%b, expected 11", {busy, in_ready});
    end
    feed(54, 8'hAA, 1'b0);
    wait_done();
    for (int i = 0; i < exq.size(); i++) begin
      checks++;
      if (i >= obs.size() || obs[i].addr !== exq[i].addr || obs[i].data !== exq[i].data) begin
        errors++; $display("FAIL busy_word%0d: got %0d writes, expected @%0d %h",
                           i, obs.size(), exq[i].addr, exq[i].data);
      end
    end
    // restart from DONE while a byte is already offered
    clear_sb();
    push_expected(8'h30, 2, 0);
    start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL done_ready: in_ready=%0b, expected 0", in_ready);
    end
    step();
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if ({done, busy} !== 2'b01 || ram_addr !== 8'd0) begin
      errors++; $display("FAIL done_restart: {done,busy}=%b addr=%0d, expected 01 addr=0",
                         {done, busy}, ram_addr);
    end
    feed(64, 8'h30, 1'b0);
    wait_done();
    checks++;
    if (obs.size() !== 2) begin
      errors++; $display("FAIL restart_count: got %0d writes, expected 2", obs.size());
    end
    for (int i = 0; i < exq.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i].addr !== exq[i].addr || obs[i].data !== exq[i].data) begin
        errors++; $display("FAIL restart_word%0d: got @%0d %h, expected @%0d %h",
                           i, obs[i].addr, obs[i].data, exq[i].addr, exq[i].data);
      end
    end
  endtask

`ifdef READBACK_VERIFY_EN
  task automatic test_verify();
    clear_sb();
    corrupt = 1'b1;
    pulse_start();
    feed(32, 8'h00, 1'b0);
    wait_done();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if ({error, done} !== 2'b11) begin
      errors++; $display("FAIL verify_err: {error,done}=%b, expected 11", {error, done});
    end
    checks++;
    if (obs.size() !== 1 || (obs.size() > 0 && obs[0].addr !== 8'd0)) begin
      errors++; $display("FAIL verify_writes: got %0d writes, expected 1 at addr 0", obs.size());
    end
    corrupt = 1'b0;
    clear_sb();
    push_expected(8'h00, 2, 0);
    pulse_start();
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL verify_clear: error=%0b, expected 0", error);
    end
    feed(64, 8'h00, 1'b0);
    wait_done();
    checks++;
    if (error !== 1'b0 || obs.size() !== 2) begin
      errors++; $display("FAIL verify_clean: error=%0b writes=%0d, expected 0 and 2", error, obs.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_random_valid();
    test_rst_mid();
    test_start_while_busy();
`ifdef READBACK_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
